// File: rtl/manchester_frame_rx.sv
// Framed IEEE 802.3 Manchester receiver: oversampled bit recovery, SFD hunt, length-prefixed
// payload delivered on AXI-Stream with a one-byte hold so the last beat can carry the CRC verdict.
module manchester_frame_rx #(
  parameter int unsigned HALF_BIT_CYCLES = 4,
  parameter logic [7:0]  SFD             = 8'hD5,
  parameter logic [7:0]  CRC_POLY        = 8'h07
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       manchester_in,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       locked,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       overflow
);

  localparam int unsigned BLANK_CYCLES = 3 * HALF_BIT_CYCLES / 2;
  localparam int unsigned IDLE_LIMIT   = 4 * HALF_BIT_CYCLES;
  localparam int unsigned BLANK_W      = $clog2(BLANK_CYCLES + 1);
  localparam int unsigned IDLE_W       = $clog2(IDLE_LIMIT + 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CRC} state_t;

  state_t              state, state_n;
  logic                sync1, sync2, sync3;
  logic [BLANK_W-1:0]  blank_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [7:0]          sr;
  logic [2:0]          bcnt;
  logic [7:0]          count;
  logic [7:0]          crc;
  logic [7:0]          hold;
  logic                have_hold;
  logic [7:0]          out_data;
  logic                out_valid, out_last, out_user, ovf_q;

  logic                line_edge, bit_strobe, bit_val, carrier_loss, byte_done;
  logic [7:0]          byte_val;
  logic                push, push_last, push_user, ovf;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    crc_step = {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
  endfunction

  assign line_edge    = sync2 ^ sync3;
  assign bit_strobe   = line_edge && (blank_cnt == '0);
  assign bit_val      = sync2;
  assign carrier_loss = !line_edge && (idle_cnt == IDLE_W'(IDLE_LIMIT - 1));
  assign byte_val     = {sr[6:0], bit_val};
  assign byte_done    = bit_strobe && (bcnt == 3'd7);

  always_comb begin
    state_n   = state;
    push      = 1'b0;
    push_last = 1'b0;
    push_user = 1'b0;
    if (carrier_loss) begin
      state_n = HUNT;
    end else begin
      case (state)
        HUNT:    if (bit_strobe && byte_val == SFD) state_n = LEN;
        LEN:     if (byte_done) state_n = (byte_val == 8'h00) ? HUNT : PAYLOAD;
        PAYLOAD: if (byte_done) begin
                   push = have_hold;
                   if (count == 8'd1) state_n = CRC;
                 end
        CRC:     if (byte_done) begin
                   push      = 1'b1;
                   push_last = 1'b1;
                   push_user = (byte_val != crc);
                   state_n   = HUNT;
                 end
        default: state_n = HUNT;
      endcase
    end
    ovf = push && out_valid && !m_axis_tready;
    if (ovf) state_n = HUNT;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= HUNT;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      blank_cnt <= '0;
      idle_cnt  <= '0;
      sr        <= '0;
      bcnt      <= '0;
      count     <= '0;
      crc       <= '0;
      hold      <= '0;
      have_hold <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state <= state_n;
      sync1 <= manchester_in;
      sync2 <= sync1;
      sync3 <= sync2;

      // Boundary edges are blanked; the counter runs out before the next mid-bit edge.
      if (bit_strobe)          blank_cnt <= BLANK_W'(BLANK_CYCLES);
      else if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;

      if (line_edge)                          idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(IDLE_LIMIT)) idle_cnt <= idle_cnt + 1'b1;

      if (carrier_loss || (state != HUNT && state_n == HUNT)) sr <= '0;
      else if (bit_strobe)                                    sr <= byte_val;

      if (state == HUNT)   bcnt <= '0;
      else if (bit_strobe) bcnt <= bcnt + 1'b1;

      if (state == HUNT)
        crc <= '0;
      else if (bit_strobe && (state == LEN || state == PAYLOAD))
        crc <= crc_step(crc, bit_val);

      if (byte_done && state == LEN)     count <= byte_val;
      if (byte_done && state == PAYLOAD) count <= count - 1'b1;

      if (byte_done && state == PAYLOAD && !ovf) begin
        hold      <= byte_val;
        have_hold <= 1'b1;
      end
      if (state_n == HUNT) have_hold <= 1'b0;

      // A push that collides with an accept still loads; only a stalled register drops it.
      if (push && !ovf) begin
        out_valid <= 1'b1;
        out_data  <= hold;
        out_last  <= push_last;
        out_user  <= push_user;
      end else if (out_valid && m_axis_tready) begin
        out_valid <= 1'b0;
      end

      ovf_q <= ovf;
    end
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;
  assign locked        = (state != HUNT);
  assign overflow      = ovf_q;
  assign frame_ok      = out_valid && m_axis_tready && out_last && !out_user;
  assign crc_err       = out_valid && m_axis_tready && out_last && out_user;

endmodule
